// File: rtl/stopwatch_cmd_sequencer_if.sv
// Button/status inputs and command outputs shared between the board front end and the stopwatch sequencer.
interface stopwatch_cmd_sequencer_if;
    logic       btn_start;
    logic       btn_stop;
    logic       btn_reset;
    logic       btn_lap;
    logic [1:0] status;
    logic       cmd_start;
    logic       cmd_stop;
    logic       cmd_reset;
    logic       cmd_lap;
    logic       cmd_drop;
    logic       busy;

    modport master (
        output btn_start, btn_stop, btn_reset, btn_lap, status,
        input  cmd_start, cmd_stop, cmd_reset, cmd_lap, cmd_drop, busy
    );

    modport slave (
        input  btn_start, btn_stop, btn_reset, btn_lap, status,
        output cmd_start, cmd_stop, cmd_reset, cmd_lap, cmd_drop, busy
    );
endinterface

// File: rtl/stopwatch_cmd_sequencer.sv
// Push-button front end: sync, debounce, rise detect, priority arbitration against FSM status,
// one-cycle command pulses with a post-command lockout.
module stopwatch_cmd_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    stopwatch_cmd_sequencer_if.slave  bus
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int LW = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES);

    // Bit order for all per-button vectors: 0 start, 1 stop, 2 reset, 3 lap.
    localparam int B_START = 0;
    localparam int B_STOP  = 1;
    localparam int B_RESET = 2;
    localparam int B_LAP   = 3;

    logic [3:0]    btn_raw;
    logic [3:0]    sync1, sync2;
    logic [3:0]    stable, stable_d;
    logic [CW-1:0] db_cnt [4];
    logic [3:0]    pend, pend_nxt, pend_clr;
    logic [LW-1:0] lock, lock_nxt;
    logic [4:0]    cmd_q, cmd_nxt;
    logic          busy_q, busy_nxt;
    logic          start_ok, run_ok;

    assign btn_raw = {bus.btn_lap, bus.btn_reset, bus.btn_stop, bus.btn_start};

    assign start_ok = (bus.status == 2'b00) || (bus.status == 2'b10);
    assign run_ok   = (bus.status == 2'b01);

    // One request handled per cycle; an invalid request is dropped without consuming lockout.
    always_comb begin
        pend_clr = '0;
        cmd_nxt  = '0;
        lock_nxt = (lock != '0) ? lock - LW'(1) : lock;
        if (lock == '0) begin
            if (pend[B_RESET]) begin
                cmd_nxt[B_RESET] = 1'b1;
                pend_clr         = 4'b1111;
                lock_nxt         = LOCK_LOAD;
            end else if (pend[B_STOP]) begin
                pend_clr[B_STOP] = 1'b1;
                if (run_ok) begin
                    cmd_nxt[B_STOP] = 1'b1;
                    lock_nxt        = LOCK_LOAD;
                end else begin
                    cmd_nxt[4] = 1'b1;
                end
            end else if (pend[B_START]) begin
                pend_clr[B_START] = 1'b1;
                if (start_ok) begin
                    cmd_nxt[B_START] = 1'b1;
                    lock_nxt         = LOCK_LOAD;
                end else begin
                    cmd_nxt[4] = 1'b1;
                end
            end else if (pend[B_LAP]) begin
                pend_clr[B_LAP] = 1'b1;
                if (run_ok) begin
                    cmd_nxt[B_LAP] = 1'b1;
                    lock_nxt       = LOCK_LOAD;
                end else begin
                    cmd_nxt[4] = 1'b1;
                end
            end
        end
        pend_nxt = (pend & ~pend_clr) | (stable & ~stable_d);
        busy_nxt = (|pend_nxt) || (lock_nxt != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            pend     <= '0;
            lock     <= '0;
            cmd_q    <= '0;
            busy_q   <= 1'b0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            stable_d <= stable;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
            pend   <= pend_nxt;
            lock   <= lock_nxt;
            cmd_q  <= cmd_nxt;
            busy_q <= busy_nxt;
        end
    end

    assign bus.cmd_start = cmd_q[B_START];
    assign bus.cmd_stop  = cmd_q[B_STOP];
    assign bus.cmd_reset = cmd_q[B_RESET];
    assign bus.cmd_lap   = cmd_q[B_LAP];
    assign bus.cmd_drop  = cmd_q[4];
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_stopwatch_cmd_sequencer.sv
// Directed bench for stopwatch_cmd_sequencer; each scenario records outputs per cycle relative to the press.
module tb_stopwatch_cmd_sequencer;

    localparam logic [4:0] C_START = 5'b00001;
    localparam logic [4:0] C_STOP  = 5'b00010;
    localparam logic [4:0] C_RESET = 5'b00100;
    localparam logic [4:0] C_LAP   = 5'b01000;
    localparam logic [4:0] C_DROP  = 5'b10000;
    localparam int         HLEN    = 40;

    logic clk = 1'b0;
    logic rst_n;

    stopwatch_cmd_sequencer_if sw_if ();

    stopwatch_cmd_sequencer #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sw_if)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         t;
    logic [4:0] h  [HLEN];
    logic       hb [HLEN];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vec++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic sample();
        h[t]  = {sw_if.cmd_drop, sw_if.cmd_lap, sw_if.cmd_reset, sw_if.cmd_stop, sw_if.cmd_start};
        hb[t] = sw_if.busy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (t < HLEN - 1) t++;
        sample();
    endtask

    task automatic begin_scn();
        for (int i = 0; i < HLEN; i++) begin
            h[i]  = 'x;
            hb[i] = 1'bx;
        end
        t = 0;
        sample();
    endtask

    task automatic run_to(input int n);
        while (t < n) tick();
    endtask

    task automatic release_and_settle();
        sw_if.btn_start = 1'b0;
        sw_if.btn_stop  = 1'b0;
        sw_if.btn_reset = 1'b0;
        sw_if.btn_lap   = 1'b0;
        repeat (16) @(posedge clk);
        #1;
    endtask

    function automatic int nz_except(input int a, input int b);
        int c = 0;
        for (int i = 0; i <= t; i++)
            if (i != a && i != b && h[i] !== 5'b0) c++;
        return c;
    endfunction

    function automatic int busy_count();
        int c = 0;
        for (int i = 0; i <= t; i++)
            if (hb[i] !== 1'b0) c++;
        return c;
    endfunction

    initial begin
        rst_n           = 1'b0;
        sw_if.btn_start = 1'b0;
        sw_if.btn_stop  = 1'b0;
        sw_if.btn_reset = 1'b0;
        sw_if.btn_lap   = 1'b0;
        sw_if.status    = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        begin_scn();
        check("reset_cmds", 32'(h[0]), 32'd0);
        check("reset_busy", 32'(hb[0]), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // 1: start held 10 cycles in IDLE
        sw_if.status = 2'b00;
        begin_scn();
        sw_if.btn_start = 1'b1;
        run_to(10);
        sw_if.btn_start = 1'b0;
        run_to(24);
        check("s1_start_at_8", 32'(h[8]), 32'(C_START));
        check("s1_no_other_out", nz_except(8, -1), 0);
        check("s1_busy_6", 32'(hb[6]), 32'd0);
        check("s1_busy_7", 32'(hb[7]), 32'd1);
        check("s1_busy_8", 32'(hb[8]), 32'd1);
        check("s1_busy_9", 32'(hb[9]), 32'd1);
        check("s1_busy_11", 32'(hb[11]), 32'd0);
        release_and_settle();

        // 2: short stop press is filtered
        sw_if.status = 2'b01;
        begin_scn();
        sw_if.btn_stop = 1'b1;
        run_to(3);
        sw_if.btn_stop = 1'b0;
        run_to(24);
        check("s2_no_out", nz_except(-1, -1), 0);
        check("s2_never_busy", busy_count(), 0);
        release_and_settle();

        // 3: start+reset together while RUNNING
        sw_if.status = 2'b01;
        begin_scn();
        sw_if.btn_start = 1'b1;
        sw_if.btn_reset = 1'b1;
        run_to(24);
        check("s3_reset_at_8", 32'(h[8]), 32'(C_RESET));
        check("s3_no_other_out", nz_except(8, -1), 0);
        release_and_settle();

        // 4a: stop+lap, status held RUNNING
        sw_if.status = 2'b01;
        begin_scn();
        sw_if.btn_stop = 1'b1;
        sw_if.btn_lap  = 1'b1;
        run_to(24);
        check("s4a_stop_at_8", 32'(h[8]), 32'(C_STOP));
        check("s4a_lap_at_11", 32'(h[11]), 32'(C_LAP));
        check("s4a_no_other_out", nz_except(8, 11), 0);
        release_and_settle();

        // 4b: stop+lap, status moves to PAUSED at cycle 9
        sw_if.status = 2'b01;
        begin_scn();
        sw_if.btn_stop = 1'b1;
        sw_if.btn_lap  = 1'b1;
        run_to(9);
        sw_if.status = 2'b10;
        run_to(24);
        check("s4b_stop_at_8", 32'(h[8]), 32'(C_STOP));
        check("s4b_drop_at_11", 32'(h[11]), 32'(C_DROP));
        check("s4b_no_other_out", nz_except(8, 11), 0);
        release_and_settle();

        // 5: bouncing reset, final rise at cycle 6
        sw_if.status = 2'b00;
        begin_scn();
        for (int i = 0; i < 6; i++) begin
            sw_if.btn_reset = ~i[0];
            tick();
        end
        sw_if.btn_reset = 1'b1;
        run_to(30);
        check("s5_reset_at_14", 32'(h[14]), 32'(C_RESET));
        check("s5_no_other_out", nz_except(14, -1), 0);
        release_and_settle();

        // 6: start press interrupted by reset at cycles 4-5, button still held
        sw_if.status = 2'b00;
        begin_scn();
        sw_if.btn_start = 1'b1;
        run_to(4);
        rst_n = 1'b0;
        run_to(6);
        rst_n = 1'b1;
        run_to(30);
        check("s6_busy_in_reset", 32'(hb[6]), 32'd0);
        check("s6_start_after_release", 32'(h[14]), 32'(C_START));
        check("s6_no_other_out", nz_except(14, -1), 0);
        release_and_settle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
